// File: rtl/bus_codes_pkg.sv
// Bus source/destination codes and the scheduler state encoding shared by the
// bus transfer scheduler, its arbiter and the requesters that drive it.
package bus_codes_pkg;

    localparam int CODE_W = 5;
    typedef logic [CODE_W-1:0] code_t;

    localparam code_t SRC_R0     = 5'd0;
    localparam code_t SRC_R1     = 5'd1;
    localparam code_t SRC_R2     = 5'd2;
    localparam code_t SRC_R3     = 5'd3;
    localparam code_t SRC_R4     = 5'd4;
    localparam code_t SRC_R5     = 5'd5;
    localparam code_t SRC_R6     = 5'd6;
    localparam code_t SRC_R7     = 5'd7;
    localparam code_t SRC_R8     = 5'd8;
    localparam code_t SRC_R9     = 5'd9;
    localparam code_t SRC_R10    = 5'd10;
    localparam code_t SRC_R11    = 5'd11;
    localparam code_t SRC_R12    = 5'd12;
    localparam code_t SRC_R13    = 5'd13;
    localparam code_t SRC_R14    = 5'd14;
    localparam code_t SRC_R15    = 5'd15;
    localparam code_t SRC_HI     = 5'd16;
    localparam code_t SRC_LO     = 5'd17;
    localparam code_t SRC_ZHI    = 5'd18;
    localparam code_t SRC_ZLO    = 5'd19;
    localparam code_t SRC_PC     = 5'd20;
    localparam code_t SRC_MDR    = 5'd21;
    localparam code_t SRC_INPORT = 5'd22;
    localparam code_t SRC_CSIGN  = 5'd23;
    localparam code_t SRC_LAST   = SRC_CSIGN;

    // 31 means "mux drives 0" on the source side and "load nothing" on the destination side.
    localparam code_t SRC_IDLE = 5'd31;
    localparam code_t DST_NONE = 5'd31;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DRIVE    = 2'd1,
        ST_WAIT_MEM = 2'd2
    } sched_state_t;

    function automatic logic src_is_valid(input code_t src);
        return (src <= SRC_LAST);
    endfunction

    function automatic logic [31:0] dst_decode(input code_t dst);
        logic [31:0] oh;
        oh = 32'd1 << dst;
        if (dst == DST_NONE) begin
            oh = '0;
        end
        return oh;
    endfunction

endpackage

// File: rtl/bus_xfer_sched_if.sv
// Request/response bundle between the transfer requesters and the bus scheduler;
// the scheduler takes the slave side, requesters the master side.
interface bus_xfer_sched_if #(
    parameter int NREQ = 4
);
    import bus_codes_pkg::*;

    localparam int IDX_W = $clog2(NREQ);

    logic [NREQ-1:0]        req;
    logic [CODE_W*NREQ-1:0] req_src;
    logic [CODE_W*NREQ-1:0] req_dst;
    logic                   mem_rdy;
    logic [NREQ-1:0]        ack;
    logic                   err;
    code_t                  bus_sel;
    logic [31:0]            dst_ld;
    logic [IDX_W-1:0]       grant_id;
    logic                   busy;

    modport slave (
        input  req, req_src, req_dst, mem_rdy,
        output ack, err, bus_sel, dst_ld, grant_id, busy
    );

    modport master (
        output req, req_src, req_dst, mem_rdy,
        input  ack, err, bus_sel, dst_ld, grant_id, busy
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr (wrapping)
// whose request survives the mask.
module rr_arbiter #(
    parameter  int NREQ  = 4,
    localparam int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ-1:0]  mask,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             valid
);

    logic [NREQ-1:0] elig;

    assign elig = req & mask;

    always_comb begin : search
        int               j;
        logic [IDX_W-1:0] idx;
        grant     = '0;
        grant_idx = '0;
        valid     = 1'b0;
        j         = 0;
        idx       = '0;
        for (int i = 0; i < NREQ; i++) begin
            j = int'(ptr) + i;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            idx = IDX_W'(j);
            if (!valid && elig[idx]) begin
                valid      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/bus_xfer_sched.sv
// Round-robin bus transfer scheduler: one source-to-destination transfer per cycle,
// with MDR-sourced transfers held until memory data is ready or a timeout fires.
module bus_xfer_sched
    import bus_codes_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 16
) (
    input logic             clock,
    input logic             reset,
    bus_xfer_sched_if.slave bus
);

    localparam int IDX_W = $clog2(NREQ);
    localparam int CNT_W = $clog2(TIMEOUT);

    sched_state_t     state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [IDX_W-1:0] ptr, ptr_nxt;
    logic [IDX_W-1:0] cur_id, cur_id_nxt;
    logic [NREQ-1:0]  cur_oh, cur_oh_nxt;
    code_t            cur_src, cur_src_nxt;
    code_t            cur_dst, cur_dst_nxt;

    logic [NREQ-1:0]  arb_mask;
    logic [NREQ-1:0]  arb_grant;
    logic [IDX_W-1:0] arb_idx;
    logic             arb_valid;
    logic             arb_en;

    code_t            bus_sel_p0, bus_sel_p1;
    logic [31:0]      dst_ld_p0, dst_ld_p1;
    logic [NREQ-1:0]  ack_p0, ack_p1;
    logic             err_p0, err_p1;
    logic             busy_p0, busy_p1;
    logic [IDX_W-1:0] grant_id_p0, grant_id_p1;

    // The requester just finished is skipped for the round in which it completes.
    assign arb_mask = (state == ST_IDLE) ? '1 : ~cur_oh;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req       (bus.req),
        .mask      (arb_mask),
        .ptr       (ptr),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .valid     (arb_valid)
    );

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        ptr_nxt     = ptr;
        cur_id_nxt  = cur_id;
        cur_oh_nxt  = cur_oh;
        cur_src_nxt = cur_src;
        cur_dst_nxt = cur_dst;
        arb_en      = 1'b0;
        bus_sel_p0  = SRC_IDLE;
        dst_ld_p0   = '0;
        ack_p0      = '0;
        err_p0      = 1'b0;
        busy_p0     = 1'b0;
        grant_id_p0 = cur_id;

        unique case (state)
            ST_IDLE: begin
                arb_en = 1'b1;
            end
            ST_DRIVE: begin
                busy_p0    = 1'b1;
                bus_sel_p0 = cur_src;
                if (!src_is_valid(cur_src)) begin
                    ack_p0 = cur_oh;
                    err_p0 = 1'b1;
                    arb_en = 1'b1;
                end else if ((cur_src == SRC_MDR) && !bus.mem_rdy) begin
                    state_nxt = ST_WAIT_MEM;
                    cnt_nxt   = '0;
                end else begin
                    ack_p0    = cur_oh;
                    dst_ld_p0 = dst_decode(cur_dst);
                    arb_en    = 1'b1;
                end
            end
            ST_WAIT_MEM: begin
                busy_p0    = 1'b1;
                bus_sel_p0 = cur_src;
                // Ready data wins over a timeout landing in the same cycle.
                if (bus.mem_rdy) begin
                    ack_p0    = cur_oh;
                    dst_ld_p0 = dst_decode(cur_dst);
                    arb_en    = 1'b1;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    ack_p0 = cur_oh;
                    err_p0 = 1'b1;
                    arb_en = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        if (arb_en) begin
            state_nxt = arb_valid ? ST_DRIVE : ST_IDLE;
            if (arb_valid) begin
                cur_id_nxt  = arb_idx;
                cur_oh_nxt  = arb_grant;
                cur_src_nxt = bus.req_src[CODE_W*arb_idx +: CODE_W];
                cur_dst_nxt = bus.req_dst[CODE_W*arb_idx +: CODE_W];
                ptr_nxt     = (arb_idx == IDX_W'(NREQ - 1)) ? '0 : arb_idx + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            ptr    <= '0;
            cur_id <= '0;
            cur_oh <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            ptr    <= ptr_nxt;
            cur_id <= cur_id_nxt;
            cur_oh <= cur_oh_nxt;
        end
    end

    always_ff @(posedge clock) begin
        cur_src <= cur_src_nxt;
        cur_dst <= cur_dst_nxt;
    end

    // p0 -> p1: bus select, load enables and handshake leave together from one register stage.
    always_ff @(posedge clock) begin
        if (reset) begin
            bus_sel_p1  <= SRC_IDLE;
            dst_ld_p1   <= '0;
            ack_p1      <= '0;
            err_p1      <= 1'b0;
            busy_p1     <= 1'b0;
            grant_id_p1 <= '0;
        end else begin
            bus_sel_p1  <= bus_sel_p0;
            dst_ld_p1   <= dst_ld_p0;
            ack_p1      <= ack_p0;
            err_p1      <= err_p0;
            busy_p1     <= busy_p0;
            grant_id_p1 <= grant_id_p0;
        end
    end

    assign bus.bus_sel  = bus_sel_p1;
    assign bus.dst_ld   = dst_ld_p1;
    assign bus.ack      = ack_p1;
    assign bus.err      = err_p1;
    assign bus.busy     = busy_p1;
    assign bus.grant_id = grant_id_p1;

endmodule

// File: tb/tb_bus_xfer_sched.sv
// Directed bench for bus_xfer_sched: reset, single transfer, round-robin, MDR wait,
// timeout, bad source / no destination, and reset during a memory wait.
module tb_bus_xfer_sched;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 16;

    logic clock = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    bus_xfer_sched_if #(.NREQ(NREQ)) bif ();

    bus_xfer_sched #(
        .NREQ    (NREQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bif)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int i, input logic [4:0] src, input logic [4:0] dst);
        bif.req_src[5*i +: 5] = src;
        bif.req_dst[5*i +: 5] = dst;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        bif.req     = '0;
        bif.req_src = '0;
        bif.req_dst = '0;
        bif.mem_rdy = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        bif.req     = 4'b1111;
        bif.req_src = '0;
        bif.req_dst = '0;
        bif.mem_rdy = 1'b1;
        tick();
        tick();
        n_tests++;
        if ({bif.bus_sel, bif.dst_ld, bif.ack, bif.err, bif.grant_id, bif.busy} !==
            {5'd31, 32'd0, 4'b0000, 1'b0, 2'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_values got sel=%0d ld=%h ack=%b err=%b gid=%0d busy=%b want sel=31 ld=0 ack=0000 err=0 gid=0 busy=0",
                     bif.bus_sel, bif.dst_ld, bif.ack, bif.err, bif.grant_id, bif.busy);
        end
        bif.req     = '0;
        bif.mem_rdy = 1'b0;
        reset       = 1'b0;
        tick();
        n_tests++;
        if ({bif.bus_sel, bif.ack, bif.busy} !== {5'd31, 4'b0000, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_idle got sel=%0d ack=%b busy=%b want sel=31 ack=0000 busy=0",
                     bif.bus_sel, bif.ack, bif.busy);
        end
    endtask

    task automatic test_single();
        do_reset();
        set_req(0, 5'd3, 5'd5);
        bif.req = 4'b0001;
        tick();
        n_tests++;
        if ({bif.bus_sel, bif.ack} !== {5'd31, 4'b0000}) begin
            n_fail++;
            $display("FAIL single_grant_cycle got sel=%0d ack=%b want sel=31 ack=0000", bif.bus_sel, bif.ack);
        end
        tick();
        n_tests++;
        if ({bif.bus_sel, bif.dst_ld, bif.ack, bif.err, bif.busy} !==
            {5'd3, 32'h0000_0020, 4'b0001, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL single_xfer got sel=%0d ld=%h ack=%b err=%b busy=%b want sel=3 ld=00000020 ack=0001 err=0 busy=1",
                     bif.bus_sel, bif.dst_ld, bif.ack, bif.err, bif.busy);
        end
        bif.req = '0;
        tick();
        n_tests++;
        if ({bif.bus_sel, bif.dst_ld, bif.ack, bif.busy} !== {5'd31, 32'd0, 4'b0000, 1'b0}) begin
            n_fail++;
            $display("FAIL single_after got sel=%0d ld=%h ack=%b busy=%b want sel=31 ld=0 ack=0000 busy=0",
                     bif.bus_sel, bif.dst_ld, bif.ack, bif.busy);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_ack [5];
        logic [1:0] exp_id  [5];
        exp_ack = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_id  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            set_req(i, 5'd0, 5'd1);
        end
        bif.req = 4'b1111;
        tick();
        for (int k = 0; k < 5; k++) begin
            tick();
            n_tests++;
            if ({bif.ack, bif.grant_id, bif.dst_ld, bif.err, bif.busy, bif.bus_sel} !==
                {exp_ack[k], exp_id[k], 32'h0000_0002, 1'b0, 1'b1, 5'd0}) begin
                n_fail++;
                $display("FAIL rr_step%0d got ack=%b gid=%0d ld=%h err=%b busy=%b sel=%0d want ack=%b gid=%0d ld=00000002 err=0 busy=1 sel=0",
                         k, bif.ack, bif.grant_id, bif.dst_ld, bif.err, bif.busy, bif.bus_sel, exp_ack[k], exp_id[k]);
            end
        end
        bif.req = '0;
    endtask

    task automatic test_mem_wait();
        do_reset();
        set_req(0, 5'd21, 5'd2);
        bif.req = 4'b0001;
        tick();
        for (int k = 0; k < 5; k++) begin
            tick();
            n_tests++;
            if ({bif.bus_sel, bif.ack, bif.dst_ld, bif.busy} !== {5'd21, 4'b0000, 32'd0, 1'b1}) begin
                n_fail++;
                $display("FAIL mem_wait%0d got sel=%0d ack=%b ld=%h busy=%b want sel=21 ack=0000 ld=0 busy=1",
                         k, bif.bus_sel, bif.ack, bif.dst_ld, bif.busy);
            end
        end
        bif.mem_rdy = 1'b1;
        tick();
        n_tests++;
        if ({bif.bus_sel, bif.ack, bif.err, bif.dst_ld} !== {5'd21, 4'b0001, 1'b0, 32'h0000_0004}) begin
            n_fail++;
            $display("FAIL mem_rdy_load got sel=%0d ack=%b err=%b ld=%h want sel=21 ack=0001 err=0 ld=00000004",
                     bif.bus_sel, bif.ack, bif.err, bif.dst_ld);
        end
        bif.req     = '0;
        bif.mem_rdy = 1'b0;
        tick();
        n_tests++;
        if ({bif.bus_sel, bif.ack, bif.busy} !== {5'd31, 4'b0000, 1'b0}) begin
            n_fail++;
            $display("FAIL mem_after got sel=%0d ack=%b busy=%b want sel=31 ack=0000 busy=0",
                     bif.bus_sel, bif.ack, bif.busy);
        end
    endtask

    task automatic test_timeout(input logic rdy_last);
        int quiet_bad;
        quiet_bad = 0;
        do_reset();
        set_req(0, 5'd21, 5'd2);
        bif.req = 4'b0001;
        tick();
        tick();
        for (int k = 0; k < TIMEOUT - 1; k++) begin
            tick();
            if ((bif.ack !== 4'b0000) || (bif.err !== 1'b0) || (bif.dst_ld !== 32'd0) || (bif.bus_sel !== 5'd21)) begin
                quiet_bad++;
            end
        end
        n_tests++;
        if (quiet_bad != 0) begin
            n_fail++;
            $display("FAIL timeout_quiet rdy_last=%b got %0d noisy cycles want 0", rdy_last, quiet_bad);
        end
        bif.mem_rdy = rdy_last;
        tick();
        n_tests++;
        if (rdy_last) begin
            if ({bif.ack, bif.err, bif.dst_ld} !== {4'b0001, 1'b0, 32'h0000_0004}) begin
                n_fail++;
                $display("FAIL timeout_rdy_wins got ack=%b err=%b ld=%h want ack=0001 err=0 ld=00000004",
                         bif.ack, bif.err, bif.dst_ld);
            end
        end else begin
            if ({bif.ack, bif.err, bif.dst_ld} !== {4'b0001, 1'b1, 32'd0}) begin
                n_fail++;
                $display("FAIL timeout_abort got ack=%b err=%b ld=%h want ack=0001 err=1 ld=0",
                         bif.ack, bif.err, bif.dst_ld);
            end
        end
        bif.req     = '0;
        bif.mem_rdy = 1'b0;
    endtask

    task automatic test_bad_src_and_no_dst();
        do_reset();
        set_req(0, 5'd25, 5'd3);
        bif.req = 4'b0001;
        tick();
        tick();
        n_tests++;
        if ({bif.ack, bif.err, bif.dst_ld} !== {4'b0001, 1'b1, 32'd0}) begin
            n_fail++;
            $display("FAIL bad_src got ack=%b err=%b ld=%h want ack=0001 err=1 ld=0", bif.ack, bif.err, bif.dst_ld);
        end
        set_req(0, 5'd7, 5'd31);
        tick();
        n_tests++;
        if ({bif.ack, bif.err} !== {4'b0000, 1'b0}) begin
            n_fail++;
            $display("FAIL pulse_single_cycle got ack=%b err=%b want ack=0000 err=0", bif.ack, bif.err);
        end
        tick();
        n_tests++;
        if ({bif.bus_sel, bif.ack, bif.err, bif.dst_ld} !== {5'd7, 4'b0001, 1'b0, 32'd0}) begin
            n_fail++;
            $display("FAIL no_dst got sel=%0d ack=%b err=%b ld=%h want sel=7 ack=0001 err=0 ld=0",
                     bif.bus_sel, bif.ack, bif.err, bif.dst_ld);
        end
        bif.req = '0;
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        set_req(2, 5'd21, 5'd2);
        bif.req = 4'b0100;
        tick();
        tick();
        n_tests++;
        if ({bif.bus_sel, bif.grant_id, bif.busy, bif.ack} !== {5'd21, 2'd2, 1'b1, 4'b0000}) begin
            n_fail++;
            $display("FAIL mid_wait_entry got sel=%0d gid=%0d busy=%b ack=%b want sel=21 gid=2 busy=1 ack=0000",
                     bif.bus_sel, bif.grant_id, bif.busy, bif.ack);
        end
        tick();
        reset       = 1'b1;
        bif.mem_rdy = 1'b1;
        tick();
        n_tests++;
        if ({bif.bus_sel, bif.dst_ld, bif.ack, bif.err, bif.grant_id, bif.busy} !==
            {5'd31, 32'd0, 4'b0000, 1'b0, 2'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL mid_reset got sel=%0d ld=%h ack=%b err=%b gid=%0d busy=%b want sel=31 ld=0 ack=0000 err=0 gid=0 busy=0",
                     bif.bus_sel, bif.dst_ld, bif.ack, bif.err, bif.grant_id, bif.busy);
        end
        reset       = 1'b0;
        bif.mem_rdy = 1'b0;
        set_req(0, 5'd4, 5'd6);
        set_req(3, 5'd5, 5'd7);
        bif.req = 4'b1001;
        tick();
        n_tests++;
        if (bif.ack !== 4'b0000) begin
            n_fail++;
            $display("FAIL mid_no_late_ack got ack=%b want ack=0000", bif.ack);
        end
        tick();
        n_tests++;
        if ({bif.bus_sel, bif.ack, bif.dst_ld, bif.grant_id} !== {5'd4, 4'b0001, 32'h0000_0040, 2'd0}) begin
            n_fail++;
            $display("FAIL mid_ptr_restart got sel=%0d ack=%b ld=%h gid=%0d want sel=4 ack=0001 ld=00000040 gid=0",
                     bif.bus_sel, bif.ack, bif.dst_ld, bif.grant_id);
        end
        bif.req = 4'b1000;
        tick();
        n_tests++;
        if ({bif.bus_sel, bif.ack, bif.dst_ld, bif.grant_id} !== {5'd5, 4'b1000, 32'h0000_0080, 2'd3}) begin
            n_fail++;
            $display("FAIL mid_back_to_back got sel=%0d ack=%b ld=%h gid=%0d want sel=5 ack=1000 ld=00000080 gid=3",
                     bif.bus_sel, bif.ack, bif.dst_ld, bif.grant_id);
        end
        bif.req = '0;
    endtask

    initial begin
        reset       = 1'b1;
        bif.req     = '0;
        bif.req_src = '0;
        bif.req_dst = '0;
        bif.mem_rdy = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_mem_wait();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_bad_src_and_no_dst();
        test_reset_mid_wait();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got simulation still running want finished");
        $fatal(1, "watchdog expired");
    end

endmodule
